aes128_iterative_encrypt: RTL and testbench

- AES-128 encryption core per FIPS-197, iterative: one cipher round per clock with on-the-fly key expansion.
- Accepts a 128-bit plaintext and a 128-bit key, produces the 128-bit ciphertext with a one-cycle valid strobe.
- Top-level crypto block of the AES datapath, driven by a simple level-enable from the system controller.

---
 rtl/aes128_iterative_encrypt.sv | 179 +++++++++++++++++
 tb/tb_aes128_iterative_encrypt.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_iterative_encrypt.sv
// AES-128 encryption core: one cipher round per clock, round keys expanded on the fly.
// Byte 0 of every 128-bit word sits in bits [127:120]; the state is column-major.
module aes128_iterative_encrypt (
  input  logic         AES_clk,
  input  logic         AES_rst,
  input  logic         AES_en,
  input  logic [127:0] AES_data_in,
  input  logic [127:0] AES_key_in,
  output logic [127:0] AES_data_out,
  output logic         AES_data_out_valid
);

  localparam int unsigned BLOCK_W    = 128;
  localparam int unsigned ROUND_W    = 4;
  localparam int unsigned LAST_ROUND = 10;

  typedef enum logic {IDLE, RUN} fsm_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [BLOCK_W-1:0] sub_bytes(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[127 - 8*i -: 8] = SBOX[s[127 - 8*i -: 8]];
    end
    return o;
  endfunction

  // Row r of the state rotates left by r columns.
  function automatic logic [BLOCK_W-1:0] shift_rows(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [BLOCK_W-1:0] mix_columns(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [ROUND_W-1:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // Derives the next round key from the current one in a single step.
  function automatic logic [BLOCK_W-1:0] key_step(input logic [BLOCK_W-1:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, rot, sw;
    w0  = k[127:96];
    w1  = k[95:64];
    w2  = k[63:32];
    w3  = k[31:0];
    rot = {w3[23:0], w3[31:24]};
    sw  = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]};
    w0  = w0 ^ sw ^ {rc, 24'h000000};
    w1  = w1 ^ w0;
    w2  = w2 ^ w1;
    w3  = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  fsm_e               fsm_q, fsm_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic [BLOCK_W-1:0] state_q, state_d;
  logic [BLOCK_W-1:0] rkey_q, rkey_d;
  logic [BLOCK_W-1:0] data_out_q, data_out_d;
  logic               valid_q, valid_d;
  logic [BLOCK_W-1:0] next_key;
  logic [BLOCK_W-1:0] sr_state;

  // Next-state and round datapath.
  always_comb begin
    fsm_d      = fsm_q;
    round_d    = round_q;
    state_d    = state_q;
    rkey_d     = rkey_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    next_key   = key_step(rkey_q, rcon(round_q));
    sr_state   = shift_rows(sub_bytes(state_q));
    case (fsm_q)
      IDLE: begin
        if (AES_en) begin
          state_d = AES_data_in ^ AES_key_in;
          rkey_d  = AES_key_in;
          round_d = ROUND_W'(1);
          fsm_d   = RUN;
        end
      end
      RUN: begin
        rkey_d = next_key;
        if (round_q == ROUND_W'(LAST_ROUND)) begin
          data_out_d = sr_state ^ next_key;
          valid_d    = 1'b1;
          round_d    = '0;
          fsm_d      = IDLE;
        end else begin
          state_d = mix_columns(sr_state) ^ next_key;
          round_d = round_q + ROUND_W'(1);
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge AES_clk) begin
    if (AES_rst) begin
      fsm_q      <= IDLE;
      round_q    <= '0;
      state_q    <= '0;
      rkey_q     <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      round_q    <= round_d;
      state_q    <= state_d;
      rkey_q     <= rkey_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
    end
  end

  assign AES_data_out       = data_out_q;
  assign AES_data_out_valid = valid_q;

endmodule

// File: tb/tb_aes128_iterative_encrypt.sv
// Self-checking bench for aes128_iterative_encrypt: known-answer vectors plus random
// blocks against a byte-array AES model whose S-box is derived from GF(2^8) arithmetic.
module tb_aes128_iterative_encrypt;

  logic         clk;
  logic         rst;
  logic         en;
  logic [127:0] data_in;
  logic [127:0] key_in;
  logic [127:0] data_out;
  logic         valid;

  int vectors;
  int miscompares;

  logic [7:0] sbox_t [256];

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

  aes128_iterative_encrypt dut (
    .AES_clk            (clk),
    .AES_rst            (rst),
    .AES_en             (en),
    .AES_data_in        (data_in),
    .AES_key_in         (key_in),
    .AES_data_out       (data_out),
    .AES_data_out_valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, need finished");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [127:0] o;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h000000};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = pt[127 - 8*(4*c + r) -: 8] ^ w[c][31 - 8*r -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = sbox_t[s[r][(c + r) % 4]];
      for (int c = 0; c < 4; c++) begin
        for (int r = 0; r < 4; r++) begin
          if (rnd < 10)
            s[r][c] = gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c]) ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
          else
            s[r][c] = t[r][c];
        end
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[r][c] = s[r][c] ^ w[4*rnd + c][31 - 8*r -: 8];
    end
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = s[r][c];
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Pulses AES_en for one cycle, scrambles the inputs afterwards, and reports the
  // result, the edge count to valid (-1 on timeout) and whether valid lasted one cycle.
  task automatic encrypt_once(input logic [127:0] pt, input logic [127:0] key,
                              output logic [127:0] res, output int lat, output logic one_cycle);
    res       = '0;
    lat       = -1;
    one_cycle = 1'b0;
    @(negedge clk);
    data_in = pt;
    key_in  = key;
    en      = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      en      = 1'b0;
      data_in = rand128();
      key_in  = rand128();
      if (valid === 1'b1) begin
        lat = k;
        res = data_out;
        @(negedge clk);
        one_cycle = (valid === 1'b0);
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic seen;
    rst     = 1'b1;
    en      = 1'b0;
    data_in = '0;
    key_in  = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if (data_out !== 128'h0) begin
      miscompares++;
      $display("FAIL reset_out: got %h need %h", data_out, 128'h0);
    end
    vectors++;
    if (valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_valid: got %b need 0", valid);
    end
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid !== 1'b0) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_no_valid: got valid seen=%b need 0", seen);
    end
  endtask

  task automatic test_known_vectors();
    logic [127:0] kv_key [3];
    logic [127:0] kv_pt  [3];
    logic [127:0] kv_ct  [3];
    logic [127:0] res;
    int           lat;
    logic         one;
    kv_key[0] = KEY_B;
    kv_pt[0]  = PT_B;
    kv_ct[0]  = CT_B;
    kv_key[1] = 128'h000102030405060708090a0b0c0d0e0f;
    kv_pt[1]  = 128'h00112233445566778899aabbccddeeff;
    kv_ct[1]  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    kv_key[2] = 128'h0;
    kv_pt[2]  = 128'h0;
    kv_ct[2]  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    for (int v = 0; v < 3; v++) begin
      encrypt_once(kv_pt[v], kv_key[v], res, lat, one);
      vectors++;
      if (res !== kv_ct[v]) begin
        miscompares++;
        $display("FAIL kat%0d_data: got %h need %h", v, res, kv_ct[v]);
      end
      vectors++;
      if (lat !== 11) begin
        miscompares++;
        $display("FAIL kat%0d_latency: got %0d need 11", v, lat);
      end
      vectors++;
      if (one !== 1'b1) begin
        miscompares++;
        $display("FAIL kat%0d_pulse_width: got one_cycle=%b need 1", v, one);
      end
    end
  endtask

  task automatic test_random();
    logic [127:0] pt, key, res, exp;
    int           lat;
    logic         one;
    for (int n = 0; n < 8; n++) begin
      pt  = rand128();
      key = rand128();
      exp = aes_ref(pt, key);
      encrypt_once(pt, key, res, lat, one);
      vectors++;
      if (res !== exp || lat !== 11) begin
        miscompares++;
        $display("FAIL random%0d: got %h lat %0d need %h lat 11", n, res, lat, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic exp_v;
    int   pulses;
    pulses = 0;
    @(negedge clk);
    data_in = PT_B;
    key_in  = KEY_B;
    en      = 1'b1;
    for (int e = 1; e <= 81; e++) begin
      @(negedge clk);
      if (e == 51) en = 1'b0;
      if (e >= 51) data_in = rand128();
      exp_v = (e % 11 == 0) && (e <= 55);
      if (valid === 1'b1) pulses++;
      vectors++;
      if (valid !== exp_v) begin
        miscompares++;
        $display("FAIL b2b_valid_edge%0d: got %b need %b", e, valid, exp_v);
      end
      if (e >= 11) begin
        vectors++;
        if (data_out !== CT_B) begin
          miscompares++;
          $display("FAIL b2b_data_edge%0d: got %h need %h", e, data_out, CT_B);
        end
      end
    end
    vectors++;
    if (pulses !== 5) begin
      miscompares++;
      $display("FAIL b2b_pulse_count: got %0d need 5", pulses);
    end
  endtask

  task automatic test_reset_midrun();
    logic [127:0] pt, key, res, exp;
    int           lat;
    logic         seen, one;
    @(negedge clk);
    data_in = rand128();
    key_in  = rand128();
    en      = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (data_out !== 128'h0 || valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midrun_reset: got out %h valid %b need out 0 valid 0", data_out, valid);
    end
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (valid !== 1'b0) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL midrun_aborted_valid: got valid seen=%b need 0", seen);
    end
    pt  = rand128();
    key = rand128();
    exp = aes_ref(pt, key);
    encrypt_once(pt, key, res, lat, one);
    vectors++;
    if (res !== exp || lat !== 11 || one !== 1'b1) begin
      miscompares++;
      $display("FAIL midrun_recover: got %h lat %0d one %b need %h lat 11 one 1", res, lat, one, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    en          = 1'b0;
    data_in     = '0;
    key_in      = '0;
    build_sbox();
    test_reset();
    test_known_vectors();
    test_random();
    test_back_to_back();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
